rename_unit: RTL
================

RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 SHALL have parameter N_LOG, default 32, meaning number of architectural registers.
REQ-002 SHALL have parameter N_PHYS, default 64, meaning number of physical registers (free-list depth = N_PHYS-N_LOG = 32).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have inputs dec_valid_i (1), dec_rs1_i/dec_rs2_i/dec_rd_i (5 each), dec_rs1_valid_i/dec_rs2_valid_i (1 each), dec_rd_used_i (1, decode RegWrite), dec_is_branch_i (1), dec_payload_i (pipeline_types::ctrl_payload_t).
REQ-006 SHALL have output dec_ready_o, 1, meaning an instruction is accepted this cycle when dec_valid_i is also high.
REQ-007 SHALL have outputs ren_valid_o (1), ren_ps1_o/ren_ps2_o/ren_pd_o/ren_pd_old_o (6 each), ren_rd_used_o (1), ren_payload_o (ctrl_payload_t), and input ren_ready_i (1) from dispatch.
REQ-008 SHALL have inputs commit_free_valid_i (1) and commit_free_preg_i (6), meaning ROB returns a stale physical register.
REQ-009 SHALL have inputs branch_resolve_i (1), meaning the checkpointed branch resolved correctly, and recover_i (1), meaning it mispredicted.

Function
REQ-010 SHALL hold a speculative map table RAT[32] x 6 bits, a circular free list of 32 x 6-bit entries with 6-bit head/tail pointers (5-bit index + wrap bit), one checkpoint (RAT copy + head), and ckpt_valid.
REQ-011 SHALL compute free_count = tail - head (6-bit modular); empty when 0, never exceeding 32.
REQ-012 SHALL drive dec_ready_o = (!ren_valid_o || ren_ready_i) && !recover_i && !(alloc_needed && free_count==0) && !(dec_is_branch_i && ckpt_valid && !branch_resolve_i), where alloc_needed = dec_rd_used_i && dec_rd_i!=0.
REQ-013 SHALL, on accept, read ren_ps1/ps2 from RAT before this instruction's own RAT write; a source with valid=0 yields 0.
REQ-014 SHALL, on accept with alloc_needed, output pd = freelist[head], pd_old = RAT[rd], write RAT[rd]=pd and increment head; otherwise pd=0, pd_old=0, rd_used_o=0, no head change.
REQ-015 SHALL register all ren_* outputs: latency exactly 1 cycle from accept to ren_valid_o; outputs held stable while ren_valid_o && !ren_ready_i.
REQ-016 SHALL clear ren_valid_o after a handshake with no new accept in the same cycle.
REQ-017 SHALL, on commit_free_valid_i with preg!=0, write freelist[tail]=preg and increment tail; preg 0 ignored; freed entry not allocatable until next cycle (no bypass).
REQ-018 SHALL allow simultaneous allocate and free in one cycle; free_count unchanged.
REQ-019 SHALL, on accepting a branch, copy RAT and head into the checkpoint and set ckpt_valid; a second branch stalls while ckpt_valid unless branch_resolve_i is high that cycle.
REQ-020 SHALL clear ckpt_valid on branch_resolve_i.
REQ-021 SHALL, on recover_i with ckpt_valid: RAT<=checkpoint RAT, head<=checkpoint head, ckpt_valid<=0, ren_valid_o<=0; tail and same-cycle commit frees still applied.
REQ-022 SHALL, on recover_i without ckpt_valid, only clear ren_valid_o.
REQ-023 SHALL give recover_i priority over branch_resolve_i in the same cycle.
REQ-024 SHALL keep RAT[0]=0 permanently.

Reset
REQ-025 SHALL on reset set RAT[i]=i, freelist[k]=32+k, head=0, tail=32 (count 32), ckpt_valid=0.
REQ-026 SHALL on reset set ren_valid_o=0 and all ren_* data outputs to 0; reset mid-operation discards in-flight state identically.

Verification
REQ-027 SHALL cover: after reset, ADDI x5 accepted -> next cycle ren_valid_o=1, ps1=RAT[rs1], pd=32, pd_old=5.
REQ-028 SHALL cover: back-to-back ADD x6,x5,x5 after ADDI x5 -> ps1=ps2=32, pd=33, pd_old=6.
REQ-029 SHALL cover: 32 allocations with no frees -> dec_ready_o=0 on 33rd; one commit free of p7 -> next cycle accept, pd=7.
REQ-030 SHALL cover: ren_ready_i=0 for 3 cycles -> ren_* unchanged, dec_ready_o=0; SW (rd_used=0) -> pd=0, head unchanged.
REQ-031 SHALL cover: BNE accepted at head=2, then ADDI x5 (pd=34), recover_i -> RAT[5] restored, head=2, next x5 write gets pd=34 again.
REQ-032 SHALL cover: second BNE with ckpt_valid stalls; branch_resolve_i same cycle -> accepted, new checkpoint taken.

Source files
------------

// File: rtl/rename_unit_if.sv
// Shared payload type and the decode/rename/dispatch/commit bundle for rename_unit.
package pipeline_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  uop;
  } ctrl_payload_t;
endpackage

interface rename_unit_if #(
  parameter int unsigned N_LOG  = 32,
  parameter int unsigned N_PHYS = 64
);
  localparam int unsigned AW = $clog2(N_LOG);
  localparam int unsigned PW = $clog2(N_PHYS);

  // decode -> rename
  logic                         dec_valid_i;
  logic                         dec_ready_o;
  logic [AW-1:0]                dec_rs1_i;
  logic [AW-1:0]                dec_rs2_i;
  logic [AW-1:0]                dec_rd_i;
  logic                         dec_rs1_valid_i;
  logic                         dec_rs2_valid_i;
  logic                         dec_rd_used_i;
  logic                         dec_is_branch_i;
  pipeline_types::ctrl_payload_t dec_payload_i;

  // rename -> dispatch
  logic                         ren_valid_o;
  logic                         ren_ready_i;
  logic [PW-1:0]                ren_ps1_o;
  logic [PW-1:0]                ren_ps2_o;
  logic [PW-1:0]                ren_pd_o;
  logic [PW-1:0]                ren_pd_old_o;
  logic                         ren_rd_used_o;
  pipeline_types::ctrl_payload_t ren_payload_o;

  // commit / branch resolution
  logic                         commit_free_valid_i;
  logic [PW-1:0]                commit_free_preg_i;
  logic                         branch_resolve_i;
  logic                         recover_i;

  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rs1_valid_i,
           dec_rs2_valid_i, dec_rd_used_i, dec_is_branch_i, dec_payload_i,
           ren_ready_i, commit_free_valid_i, commit_free_preg_i,
           branch_resolve_i, recover_i,
    input  dec_ready_o, ren_valid_o, ren_ps1_o, ren_ps2_o, ren_pd_o,
           ren_pd_old_o, ren_rd_used_o, ren_payload_o
  );

  modport slave (
    input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rs1_valid_i,
           dec_rs2_valid_i, dec_rd_used_i, dec_is_branch_i, dec_payload_i,
           ren_ready_i, commit_free_valid_i, commit_free_preg_i,
           branch_resolve_i, recover_i,
    output dec_ready_o, ren_valid_o, ren_ps1_o, ren_ps2_o, ren_pd_o,
           ren_pd_old_o, ren_rd_used_o, ren_payload_o
  );
endinterface

// File: rtl/rename_unit.sv
// Register rename stage: speculative RAT, circular free list, single branch checkpoint.
module rename_unit #(
  parameter int unsigned N_LOG  = 32,
  parameter int unsigned N_PHYS = 64
) (
  input logic          clk,
  input logic          reset,
  rename_unit_if.slave rn
);
  localparam int unsigned AW       = $clog2(N_LOG);
  localparam int unsigned PW       = $clog2(N_PHYS);
  localparam int unsigned FL_DEPTH = N_PHYS - N_LOG;
  localparam int unsigned FI       = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W    = FI + 1;

  logic [PW-1:0]    rat       [N_LOG];
  logic [PW-1:0]    rat_upd   [N_LOG];
  logic [PW-1:0]    ckpt_rat  [N_LOG];
  logic [PW-1:0]    free_list [FL_DEPTH];
  logic [PTR_W-1:0] head, tail, ckpt_head, head_next, free_count;
  logic             ckpt_valid;

  logic                          ren_valid_q, ren_rd_used_q;
  logic [PW-1:0]                 ren_ps1_q, ren_ps2_q, ren_pd_q, ren_pd_old_q;
  pipeline_types::ctrl_payload_t ren_payload_q;

  logic          alloc_needed, accept, do_alloc, freeing, dec_ready;
  logic [PW-1:0] new_pd;

  assign free_count   = tail - head;
  assign alloc_needed = rn.dec_rd_used_i && (rn.dec_rd_i != '0);
  assign dec_ready    = (!ren_valid_q || rn.ren_ready_i) && !rn.recover_i
                        && !(alloc_needed && (free_count == '0))
                        && !(rn.dec_is_branch_i && ckpt_valid && !rn.branch_resolve_i);
  assign accept       = rn.dec_valid_i && dec_ready;
  assign do_alloc     = accept && alloc_needed;
  assign freeing      = rn.commit_free_valid_i && (rn.commit_free_preg_i != '0);
  assign new_pd       = free_list[head[FI-1:0]];
  assign head_next    = do_alloc ? head + PTR_W'(1) : head;

  // RAT as it will look after this cycle's allocation (checkpoint captures it too)
  always_comb begin
    rat_upd = rat;
    if (do_alloc)
      rat_upd[rn.dec_rd_i] = new_pd;
  end

  // Map table, free list, checkpoint and registered rename outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_LOG; i++) begin
        rat[i]      <= PW'(i);
        ckpt_rat[i] <= '0;
      end
      for (int unsigned k = 0; k < FL_DEPTH; k++)
        free_list[k] <= PW'(N_LOG + k);
      head          <= '0;
      tail          <= PTR_W'(FL_DEPTH);
      ckpt_head     <= '0;
      ckpt_valid    <= 1'b0;
      ren_valid_q   <= 1'b0;
      ren_rd_used_q <= 1'b0;
      ren_ps1_q     <= '0;
      ren_ps2_q     <= '0;
      ren_pd_q      <= '0;
      ren_pd_old_q  <= '0;
      ren_payload_q <= '0;
    end else begin
      // Frees land in the tail even during recovery; no same-cycle bypass to head
      if (freeing) begin
        free_list[tail[FI-1:0]] <= rn.commit_free_preg_i;
        tail                    <= tail + PTR_W'(1);
      end
      if (rn.recover_i) begin
        ren_valid_q <= 1'b0;
        if (ckpt_valid) begin
          rat        <= ckpt_rat;
          head       <= ckpt_head;
          ckpt_valid <= 1'b0;
        end
      end else begin
        if (rn.branch_resolve_i)
          ckpt_valid <= 1'b0;
        if (accept) begin
          rat           <= rat_upd;
          head          <= head_next;
          ren_valid_q   <= 1'b1;
          ren_ps1_q     <= rn.dec_rs1_valid_i ? rat[rn.dec_rs1_i] : '0;
          ren_ps2_q     <= rn.dec_rs2_valid_i ? rat[rn.dec_rs2_i] : '0;
          ren_pd_q      <= do_alloc ? new_pd : '0;
          ren_pd_old_q  <= do_alloc ? rat[rn.dec_rd_i] : '0;
          ren_rd_used_q <= alloc_needed;
          ren_payload_q <= rn.dec_payload_i;
          // Later assignment overrides a same-cycle resolve clear
          if (rn.dec_is_branch_i) begin
            ckpt_rat   <= rat_upd;
            ckpt_head  <= head_next;
            ckpt_valid <= 1'b1;
          end
        end else if (rn.ren_ready_i) begin
          ren_valid_q <= 1'b0;
        end
      end
    end
  end

  assign rn.dec_ready_o   = dec_ready;
  assign rn.ren_valid_o   = ren_valid_q;
  assign rn.ren_ps1_o     = ren_ps1_q;
  assign rn.ren_ps2_o     = ren_ps2_q;
  assign rn.ren_pd_o      = ren_pd_q;
  assign rn.ren_pd_old_o  = ren_pd_old_q;
  assign rn.ren_rd_used_o = ren_rd_used_q;
  assign rn.ren_payload_o = ren_payload_q;
endmodule
